// File: rtl/layer_tdm.sv
// -----------------------------------------------------------------------------
// layer_tdm
//   Time-multiplexed fully-connected layer. NN neurons are evaluated on LANES
//   parallel MAC lanes in NN/LANES passes over a locally buffered input vector.
//   Weights/biases arrive over the shared layer config bus. The input side and
//   the output side use valid/ready flow control. Each result gets the bias
//   added, is rescaled, saturated and optionally passed through a ReLU.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   weightValid/Value   weight write strobe / data (low DATA_WIDTH bits used)
//   biasValid/Value     bias write strobe / data (low DATA_WIDTH bits used)
//   config_layer_num    target layer of a config write
//   config_neuron_num   target neuron of a config write
//   x_valid/x_ready/x_in  input element stream, index order 0..NUM_WEIGHT-1
//   y_valid/y_ready/y_out output element stream
//   y_idx, y_last       neuron index of y_out, flag for the final neuron
//   busy                frame in progress
// -----------------------------------------------------------------------------
module layer_tdm #(
    parameter int NN         = 30,
    parameter int NUM_WEIGHT = 784,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LAYER_NUM  = 1,
    parameter int LANES      = 5,
    parameter int ACT        = 1,
    localparam int IDX_W     = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  weightValid,
    input  logic                  biasValid,
    input  logic [31:0]           weightValue,
    input  logic [31:0]           biasValue,
    input  logic [31:0]           config_layer_num,
    input  logic [31:0]           config_neuron_num,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [IDX_W-1:0]      y_idx,
    output logic                  y_last,
    output logic                  busy
);
    localparam int NPASS     = NN / LANES;
    localparam int AW        = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int CW        = $clog2(NUM_WEIGHT + 2);
    localparam int PW        = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MEM_DEPTH = NPASS * NUM_WEIGHT;
    localparam int MAW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int ACC_W     = 2 * DATA_WIDTH + $clog2(NUM_WEIGHT);
    // One guard bit so acc + (bias << FRAC_BITS) can never wrap.
    localparam int SUM_W     = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_FINAL   = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;      // input beat count in LOAD, cycle count in COMPUTE
    logic [PW-1:0]   r_pass;
    logic [LW-1:0]   r_lane;
    logic [AW-1:0]   r_wptr;
    logic            r_rd_v;
    logic            r_prod_v;

    logic signed [DATA_WIDTH-1:0] r_xbuf [NUM_WEIGHT];
    logic signed [DATA_WIDTH-1:0] r_x_rd;
    logic signed [DATA_WIDTH-1:0] r_bias [NN];
    logic signed [DATA_WIDTH-1:0] w_res  [LANES];

    logic            w_cfg_hit;
    logic [LW-1:0]   w_cfg_lane;
    logic [MAW-1:0]  w_wr_addr;
    logic [IDX_W-1:0] w_cfg_idx;
    logic            w_x_fire;
    logic            w_y_fire;
    logic            w_issue;
    logic [AW-1:0]   w_rd_cnt;
    logic [MAW-1:0]  w_rd_addr;
    logic            w_acc_clr;
    logic            w_unused;

    assign w_unused = &{1'b0, weightValue[31:DATA_WIDTH], biasValue[31:DATA_WIDTH]};

    // Neuron n lives in lane n % LANES at memory row n / LANES, so one pass
    // reads a single row from every lane in parallel.
    assign w_cfg_hit  = (r_state == S_IDLE) && (config_layer_num == 32'(LAYER_NUM))
                        && (config_neuron_num < 32'(NN));
    assign w_cfg_lane = LW'(config_neuron_num % 32'(LANES));
    assign w_wr_addr  = MAW'((config_neuron_num / 32'(LANES)) * 32'(NUM_WEIGHT) + 32'(r_wptr));
    assign w_cfg_idx  = IDX_W'(config_neuron_num);

    assign x_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign y_valid  = (r_state == S_OUTPUT);
    assign w_x_fire = x_valid && x_ready;
    assign w_y_fire = y_valid && y_ready;
    assign w_issue  = (r_state == S_COMPUTE) && (r_cnt < CW'(NUM_WEIGHT));
    assign w_rd_cnt = w_issue ? r_cnt[AW-1:0] : '0;
    assign w_rd_addr = MAW'(32'(r_pass) * 32'(NUM_WEIGHT) + 32'(w_rd_cnt));
    assign w_acc_clr = (w_x_fire && (r_cnt == CW'(NUM_WEIGHT-1)))
                       || (w_y_fire && (r_lane == LW'(LANES-1)) && (r_pass != PW'(NPASS-1)));

    assign y_idx  = IDX_W'(32'(r_pass) * 32'(LANES) + 32'(r_lane));
    assign y_last = y_valid && (y_idx == IDX_W'(NN-1));
    assign y_out  = y_valid ? w_res[r_lane] : '0;

    // Input buffer and bias table: plain storage, untouched by reset.
    always_ff @(posedge clk) begin
        if (w_x_fire)
            r_xbuf[r_cnt[AW-1:0]] <= x_in;
        r_x_rd <= r_xbuf[w_rd_cnt];
        if (biasValid && w_cfg_hit)
            r_bias[w_cfg_idx] <= biasValue[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pass   <= '0;
            r_lane   <= '0;
            r_wptr   <= '0;
            r_rd_v   <= 1'b0;
            r_prod_v <= 1'b0;
        end else begin
            r_rd_v   <= w_issue;
            r_prod_v <= r_rd_v;
            if (weightValid && w_cfg_hit)
                r_wptr <= (r_wptr == AW'(NUM_WEIGHT-1)) ? '0 : r_wptr + 1'b1;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_x_fire) begin
                        if (r_cnt == CW'(NUM_WEIGHT-1)) begin
                            r_state <= S_COMPUTE;
                            r_cnt   <= '0;
                            r_pass  <= '0;
                        end else begin
                            r_state <= S_LOAD;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    // Two extra cycles drain the read and multiply stages.
                    if (r_cnt == CW'(NUM_WEIGHT+1)) begin
                        r_state <= S_FINAL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINAL: begin
                    r_state <= S_OUTPUT;
                    r_lane  <= '0;
                end
                S_OUTPUT: begin
                    if (w_y_fire) begin
                        if (r_lane == LW'(LANES-1)) begin
                            r_lane <= '0;
                            if (r_pass == PW'(NPASS-1)) begin
                                r_pass  <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_pass  <= r_pass + 1'b1;
                                r_cnt   <= '0;
                                r_state <= S_COMPUTE;
                            end
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [DATA_WIDTH-1:0]   r_wmem [MEM_DEPTH];
            logic signed [DATA_WIDTH-1:0]   r_w_rd;
            logic signed [2*DATA_WIDTH-1:0] r_prod;
            logic signed [ACC_W-1:0]        r_acc;
            logic signed [DATA_WIDTH-1:0]   r_res;
            logic [IDX_W-1:0]               w_nidx;
            logic signed [SUM_W-1:0]        w_sum;
            logic signed [SUM_W-1:0]        w_shift;
            logic signed [DATA_WIDTH-1:0]   w_sat;
            logic signed [DATA_WIDTH-1:0]   w_act;

            always_ff @(posedge clk) begin
                if (weightValid && w_cfg_hit && (w_cfg_lane == LW'(gi)))
                    r_wmem[w_wr_addr] <= weightValue[DATA_WIDTH-1:0];
                r_w_rd <= r_wmem[w_rd_addr];
            end

            assign w_nidx  = IDX_W'(32'(r_pass) * 32'(LANES) + 32'(gi));
            assign w_sum   = SUM_W'(r_acc) + (SUM_W'(r_bias[w_nidx]) <<< FRAC_BITS);
            assign w_shift = w_sum >>> FRAC_BITS;
            assign w_sat   = (w_shift > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                             (w_shift < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                             w_shift[DATA_WIDTH-1:0];
            assign w_act   = ((ACT == 1) && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
            assign w_res[gi] = r_res;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_prod <= '0;
                    r_acc  <= '0;
                    r_res  <= '0;
                end else begin
                    r_prod <= r_x_rd * r_w_rd;
                    if (w_acc_clr)
                        r_acc <= '0;
                    else if (r_prod_v)
                        r_acc <= r_acc + ACC_W'(r_prod);
                    if (r_state == S_FINAL)
                        r_res <= w_act;
                end
            end
        end
    endgenerate
endmodule
